rs_int: RTL

- Integer reservation station, directly downstream of dispatch.
- Holds renamed instructions until both source operands are valid, snooping the common data bus (CDB) for results.
- Issues one ready instruction per cycle to the integer functional unit through a registered issue port.
- Flushed wholesale on ROB mispredict/exception recovery.

---
 rtl/rs_int.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rs_int.sv
// ============================================================================
// rs_int : integer reservation station with CDB wakeup and registered issue
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rs_int #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TAG_WIDTH  = 6,
   parameter int RS_DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    flush,
   input  logic                    dispatch_en,
   output logic                    dispatch_stall,
   input  logic [6:0]              dispatch_opcode,
   input  logic [ADDR_WIDTH-1:0]   dispatch_iaddr,
   input  logic [31:0]             dispatch_insn,
   input  logic [TAG_WIDTH-1:0]    dispatch_dst_tag,
   input  logic [1:0]              dispatch_src_rdy,
   input  logic [2*DATA_WIDTH-1:0] dispatch_src_data,
   input  logic [2*TAG_WIDTH-1:0]  dispatch_src_tag,
   input  logic                    cdb_en,
   input  logic [TAG_WIDTH-1:0]    cdb_tag,
   input  logic [DATA_WIDTH-1:0]   cdb_data,
   input  logic                    fu_stall,
   output logic                    fu_en,
   output logic [6:0]              fu_opcode,
   output logic [ADDR_WIDTH-1:0]   fu_iaddr,
   output logic [31:0]             fu_insn,
   output logic [DATA_WIDTH-1:0]   fu_src_a,
   output logic [DATA_WIDTH-1:0]   fu_src_b,
   output logic [TAG_WIDTH-1:0]    fu_tag
);

   localparam int IDX_W = $clog2(RS_DEPTH);

   logic [RS_DEPTH-1:0]   r_valid;
   logic [6:0]            r_opcode  [RS_DEPTH];
   logic [ADDR_WIDTH-1:0] r_iaddr   [RS_DEPTH];
   logic [31:0]           r_insn    [RS_DEPTH];
   logic [TAG_WIDTH-1:0]  r_dst_tag [RS_DEPTH];
   logic [1:0]            r_rdy     [RS_DEPTH];
   logic [DATA_WIDTH-1:0] r_data    [RS_DEPTH][2];
   logic [TAG_WIDTH-1:0]  r_tag     [RS_DEPTH][2];

   logic [IDX_W-1:0]      w_free_idx;
   logic [IDX_W-1:0]      w_cand_idx;
   logic                  w_cand_vld;
   logic                  w_write;
   logic                  w_issue;
   logic [1:0]            w_new_rdy;
   logic [DATA_WIDTH-1:0] w_new_data [2];
   logic [TAG_WIDTH-1:0]  w_new_tag  [2];

   // Downward scan so the last hit is the lowest index.
   always_comb begin
      w_free_idx = '0;
      w_cand_idx = '0;
      w_cand_vld = 1'b0;
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
         if (!r_valid[i]) begin
            w_free_idx = IDX_W'(i);
         end
         if (r_valid[i] && (&r_rdy[i])) begin
            w_cand_idx = IDX_W'(i);
            w_cand_vld = 1'b1;
         end
      end
   end

   assign dispatch_stall = &r_valid;
   assign w_write        = dispatch_en && !dispatch_stall;
   assign w_issue        = w_cand_vld && !fu_stall;

   // A source broadcast on the CDB in the dispatch cycle is captured directly.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         w_new_tag[s]  = dispatch_src_tag[s*TAG_WIDTH +: TAG_WIDTH];
         w_new_data[s] = dispatch_src_data[s*DATA_WIDTH +: DATA_WIDTH];
         w_new_rdy[s]  = dispatch_src_rdy[s];
         if (!dispatch_src_rdy[s] && cdb_en && (cdb_tag == w_new_tag[s])) begin
            w_new_data[s] = cdb_data;
            w_new_rdy[s]  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_valid <= '0;
         for (int i = 0; i < RS_DEPTH; i++) begin
            r_opcode[i]  <= '0;
            r_iaddr[i]   <= '0;
            r_insn[i]    <= '0;
            r_dst_tag[i] <= '0;
            r_rdy[i]     <= '0;
            for (int s = 0; s < 2; s++) begin
               r_data[i][s] <= '0;
               r_tag[i][s]  <= '0;
            end
         end
      end else if (flush) begin
         r_valid <= '0;
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            for (int s = 0; s < 2; s++) begin
               if (r_valid[i] && !r_rdy[i][s] && cdb_en && (r_tag[i][s] == cdb_tag)) begin
                  r_data[i][s] <= cdb_data;
                  r_rdy[i][s]  <= 1'b1;
               end
            end
         end
         if (w_issue) begin
            r_valid[w_cand_idx] <= 1'b0;
         end
         // Free slot is never the candidate, so this cannot collide with issue.
         if (w_write) begin
            r_valid[w_free_idx]   <= 1'b1;
            r_opcode[w_free_idx]  <= dispatch_opcode;
            r_iaddr[w_free_idx]   <= dispatch_iaddr;
            r_insn[w_free_idx]    <= dispatch_insn;
            r_dst_tag[w_free_idx] <= dispatch_dst_tag;
            r_rdy[w_free_idx]     <= w_new_rdy;
            for (int s = 0; s < 2; s++) begin
               r_data[w_free_idx][s] <= w_new_data[s];
               r_tag[w_free_idx][s]  <= w_new_tag[s];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         fu_en     <= 1'b0;
         fu_opcode <= '0;
         fu_iaddr  <= '0;
         fu_insn   <= '0;
         fu_src_a  <= '0;
         fu_src_b  <= '0;
         fu_tag    <= '0;
      end else if (flush) begin
         fu_en <= 1'b0;
      end else if (!fu_stall) begin
         fu_en <= w_cand_vld;
         if (w_cand_vld) begin
            fu_opcode <= r_opcode[w_cand_idx];
            fu_iaddr  <= r_iaddr[w_cand_idx];
            fu_insn   <= r_insn[w_cand_idx];
            fu_src_a  <= r_data[w_cand_idx][0];
            fu_src_b  <= r_data[w_cand_idx][1];
            fu_tag    <= r_dst_tag[w_cand_idx];
         end
      end
   end

endmodule

`default_nettype wire
